// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave front-end for the single-port RAM subsystem.
// Deserialises {cmd, payload} frames from MOSI, hands them to the RAM,
// then serialises RAM read data back onto MISO.
module spi_slave_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_MAX = (FRAME_W > TX_TIMEOUT) ? FRAME_W : TX_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                route;
  logic                addr_seen;
  logic [DATA_W-1:0]   tx_shift;
  logic [FRAME_W-1:0]  rx_next;
  logic                abort;

  // rx_data as it would look after capturing the current MOSI bit
  assign rx_next = {rx_data[FRAME_W-2:0], MOSI};

  // SS_n released before the frame finished (DONE and IDLE are exempt)
  assign abort = SS_n && (state != IDLE) && (state != DONE);

  // Frame FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      route     <= 1'b0;
      addr_seen <= 1'b0;
      tx_shift  <= '0;
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      err      <= 1'b0;
      if (abort) begin
        // abort keeps addr_seen so an interrupted read-data can be retried
        state <= IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
        cnt   <= '0;
        MISO  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            MISO <= 1'b0;
            if (!SS_n) begin
              state <= CHK_CMD;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          CHK_CMD: begin
            route <= MOSI;
            cnt   <= '0;
            if (!MOSI)          state <= WRITE;
            else if (addr_seen) state <= READ_DATA;
            else                state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_data <= rx_next;
            if (cnt == CNT_W'(FRAME_W - 1)) begin
              cnt <= '0;
              if (route != rx_next[FRAME_W-1]) begin
                err   <= 1'b1;
                state <= DONE;
              end else begin
                rx_valid <= 1'b1;
                if (state == READ_DATA) begin
                  state <= WAIT_TX;
                end else begin
                  state <= DONE;
                  if (state == READ_ADD) addr_seen <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WAIT_TX: begin
            if (tx_valid) begin
              tx_shift <= tx_data;
              cnt      <= '0;
              state    <= SEND;
            end else if (cnt == CNT_W'(TX_TIMEOUT - 1)) begin
              err       <= 1'b1;
              addr_seen <= 1'b0;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SEND: begin
            if (cnt == CNT_W'(DATA_W)) begin
              MISO      <= 1'b0;
              addr_seen <= 1'b0;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              MISO     <= tx_shift[DATA_W-1];
              tx_shift <= tx_shift << 1;
              cnt      <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            MISO <= 1'b0;
            if (SS_n) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            MISO  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: randomized self-checking bench for spi_slave_param
// against a frame-level reference model.
module tb_spi_slave_param;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;
  localparam int unsigned W  = DW + 2;

  logic          clk;
  logic          rst_n;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          busy;
  logic          err;

  spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // observations since the last clear_obs
  int          ecnt;
  int          obs_vn, obs_ve, obs_en, obs_ee;
  logic [63:0] obs_m;

  // reference model state and per-frame expectations
  logic [W-1:0] m_rx = '0;
  logic         m_as = 1'b0;
  logic         e_valid, e_err, e_wait;

  function automatic void model_frame(input logic r, input logic [W-1:0] bits, input int nbits);
    e_valid = 1'b0; e_err = 1'b0; e_wait = 1'b0;
    if (nbits < int'(W)) begin
      m_rx  = (m_rx << nbits) | (bits >> (int'(W) - nbits));
      e_err = 1'b1;
    end else begin
      m_rx = bits;
      if (r != bits[W-1]) e_err = 1'b1;
      else begin
        e_valid = 1'b1;
        if (r && m_as) e_wait = 1'b1;
        else if (r)    m_as = 1'b1;
      end
    end
  endfunction

  task automatic clear_obs();
    ecnt = -1; obs_vn = 0; obs_ve = -1; obs_en = 0; obs_ee = -1; obs_m = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    ecnt++;
    if (rx_valid === 1'b1) begin obs_vn++; obs_ve = ecnt; end
    if (err === 1'b1)      begin obs_en++; obs_ee = ecnt; end
    obs_m = {obs_m[62:0], MISO};
  endtask

  // drive SS_n low, R, then nbits bits; raise SS_n early if nbits < W
  task automatic frame(input logic r, input logic [W-1:0] bits, input int nbits);
    clear_obs();
    SS_n = 1'b0; MOSI = 1'($urandom); step();
    MOSI = r; step();
    for (int i = 0; i < nbits; i++) begin MOSI = bits[W-1-i]; step(); end
    if (nbits < int'(W)) begin SS_n = 1'b1; MOSI = 1'($urandom); step(); end
  endtask

  task automatic end_frame();
    clear_obs();
    SS_n = 1'b1; tx_valid = 1'b0; step(); step();
  endtask

  // d idle cycles in WAIT_TX, one tx_valid cycle, then let the word shift out
  task automatic tx_phase(input int d, input logic [DW-1:0] txd);
    clear_obs();
    tx_valid = 1'b0;
    for (int i = 0; i < d; i++) step();
    tx_valid = 1'b1; tx_data = txd; step();
    tx_valid = 1'b0; tx_data = DW'($urandom);
    for (int i = 0; i < int'(DW) + 1; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    step(); step();
    checks++; if (MISO !== 1'b0)   begin errors++; $display("FAIL reset MISO got=%b want=0", MISO); end
    checks++; if (rx_data !== '0)  begin errors++; $display("FAIL reset rx_data got=%h want=0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset rx_valid got=%b want=0", rx_valid); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset err got=%b want=0", err); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset busy got=%b want=0", busy); end
    rst_n = 1'b1; step();
    m_rx = '0; m_as = 1'b0;
  endtask

  task automatic test_write_addr();
    frame(1'b0, 10'h0A5, W); model_frame(1'b0, 10'h0A5, W);
    checks++; if (obs_vn != 1 || obs_ve != int'(DW) + 3) begin errors++;
      $display("FAIL write_addr rx_valid pulses=%0d edge=%0d want 1 at %0d", obs_vn, obs_ve, DW + 3); end
    checks++; if (obs_en != 0) begin errors++; $display("FAIL write_addr err pulses=%0d want 0", obs_en); end
    checks++; if (rx_data !== 10'h0A5) begin errors++; $display("FAIL write_addr rx_data got=%h want=0a5", rx_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_addr busy in DONE got=%b want=1", busy); end
    end_frame();
    checks++; if (busy !== 1'b0 || obs_en != 0) begin errors++;
      $display("FAIL write_addr release busy=%b err=%0d want 0/0", busy, obs_en); end
  endtask

  task automatic test_read_flow();
    logic [W-1:0] b;
    frame(1'b1, 10'b10_0000_0011, W); model_frame(1'b1, 10'b10_0000_0011, W);
    checks++; if (obs_vn != 1 || rx_data !== 10'h203) begin errors++;
      $display("FAIL read_addr pulses=%0d rx_data=%h want 1/203", obs_vn, rx_data); end
    end_frame();
    b = {2'b11, 8'($urandom)};
    frame(1'b1, b, W); model_frame(1'b1, b, W);
    checks++; if (obs_vn != 1 || obs_en != 0 || rx_data !== b || !e_wait) begin errors++;
      $display("FAIL read_data frame pulses=%0d err=%0d rx_data=%h want 1/0/%h", obs_vn, obs_en, rx_data, b); end
    tx_phase(2, 8'hC3); m_as = 1'b0;
    checks++; if (obs_m !== 64'h186) begin errors++; $display("FAIL read_data MISO stream got=%h want=186", obs_m); end
    checks++; if (obs_en != 0 || busy !== 1'b1) begin errors++;
      $display("FAIL read_data after send err=%0d busy=%b want 0/1", obs_en, busy); end
    end_frame();
    // addr_seen cleared: next R=1 frame is a read-address, so tx_valid is ignored
    b = {2'b10, 8'($urandom)};
    frame(1'b1, b, W); model_frame(1'b1, b, W);
    tx_phase(1, 8'hFF);
    checks++; if (obs_m !== 64'h0) begin errors++; $display("FAIL addr_seen_clear MISO got=%h want=0", obs_m); end
    end_frame();
  endtask

  task automatic test_timeout();
    logic [W-1:0] b;
    if (!m_as) begin
      b = {2'b10, 8'($urandom)};
      frame(1'b1, b, W); model_frame(1'b1, b, W); end_frame();
    end
    b = {2'b11, 8'($urandom)};
    frame(1'b1, b, W); model_frame(1'b1, b, W);
    clear_obs(); tx_valid = 1'b0;
    repeat (TO) step();
    m_as = 1'b0;
    checks++; if (obs_en != 1 || obs_ee != int'(TO) - 1) begin errors++;
      $display("FAIL timeout err pulses=%0d edge=%0d want 1 at %0d", obs_en, obs_ee, TO - 1); end
    tx_valid = 1'b1; tx_data = 8'hA5;
    repeat (DW + 2) step();
    tx_valid = 1'b0;
    checks++; if (obs_m !== 64'h0 || busy !== 1'b1) begin errors++;
      $display("FAIL timeout MISO=%h busy=%b want 0/1", obs_m, busy); end
    end_frame();
    b = {2'b11, 8'($urandom)};
    frame(1'b1, b, W); model_frame(1'b1, b, W);
    tx_phase(0, 8'h5A);
    checks++; if (obs_m !== 64'h0 || e_wait) begin errors++;
      $display("FAIL timeout addr_seen clear MISO=%h want 0", obs_m); end
    end_frame();
  endtask

  task automatic test_abort();
    logic [W-1:0] b;
    for (int n = 6; n <= int'(W) - 1; n += int'(W) - 7) begin
      b = W'($urandom);
      frame(1'b0, b, n); model_frame(1'b0, b, n);
      checks++; if (obs_en != 1 || obs_ee != n + 2 || obs_vn != 0) begin errors++;
        $display("FAIL abort_%0d err=%0d@%0d valid=%0d want 1@%0d/0", n, obs_en, obs_ee, obs_vn, n + 2); end
      checks++; if (rx_data !== m_rx || busy !== 1'b0) begin errors++;
        $display("FAIL abort_%0d rx_data=%h busy=%b want %h/0", n, rx_data, busy, m_rx); end
      end_frame();
    end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] b;
    b = {2'b10, 8'($urandom)};
    frame(1'b0, b, W); model_frame(1'b0, b, W);
    checks++; if (obs_en != 1 || obs_ee != int'(DW) + 3 || obs_vn != 0 || rx_data !== b) begin errors++;
      $display("FAIL mismatch_w err=%0d@%0d valid=%0d rx_data=%h want 1@%0d/0/%h", obs_en, obs_ee, obs_vn, rx_data, DW + 3, b); end
    end_frame();
    b = {2'b01, 8'($urandom)};
    frame(1'b1, b, W); model_frame(1'b1, b, W);
    checks++; if (obs_en != 1 || obs_vn != 0) begin errors++;
      $display("FAIL mismatch_r err=%0d valid=%0d want 1/0", obs_en, obs_vn); end
    end_frame();
  endtask

  task automatic test_random();
    logic [W-1:0]  b;
    logic [DW-1:0] txd;
    logic          r;
    int            nb, d, sub;
    for (int it = 0; it < 40; it++) begin
      r  = 1'($urandom);
      b  = W'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : int'(W);
      frame(r, b, nb); model_frame(r, b, nb);
      checks++; if (obs_vn != int'(e_valid) || (e_valid && obs_ve != int'(DW) + 3)) begin errors++;
        $display("FAIL rand%0d rx_valid pulses=%0d edge=%0d want %0d", it, obs_vn, obs_ve, e_valid); end
      checks++; if (obs_en != int'(e_err) || (e_err && obs_ee != ((nb < int'(W)) ? nb + 2 : int'(DW) + 3))) begin errors++;
        $display("FAIL rand%0d err pulses=%0d edge=%0d want %0d", it, obs_en, obs_ee, e_err); end
      checks++; if (rx_data !== m_rx) begin errors++;
        $display("FAIL rand%0d rx_data got=%h want=%h", it, rx_data, m_rx); end
      if (e_wait) begin
        sub = int'($urandom_range(0, 3));
        d   = int'($urandom_range(0, TO - 1));
        txd = DW'($urandom);
        if (sub == 0) begin
          tx_phase(d, txd); m_as = 1'b0;
          checks++; if (obs_m !== (64'(txd) << 1) || obs_en != 0) begin errors++;
            $display("FAIL rand%0d send MISO=%h err=%0d want %h/0", it, obs_m, obs_en, 64'(txd) << 1); end
        end else if (sub == 1) begin
          clear_obs(); repeat (TO) step(); m_as = 1'b0;
          checks++; if (obs_en != 1 || obs_ee != int'(TO) - 1) begin errors++;
            $display("FAIL rand%0d timeout err=%0d@%0d want 1@%0d", it, obs_en, obs_ee, TO - 1); end
        end else if (sub == 2) begin
          clear_obs(); repeat (d % (TO - 1)) step();
          SS_n = 1'b1; step();
          checks++; if (obs_en != 1 || busy !== 1'b0) begin errors++;
            $display("FAIL rand%0d wait abort err=%0d busy=%b want 1/0", it, obs_en, busy); end
        end else begin
          clear_obs(); tx_valid = 1'b1; tx_data = txd; step(); tx_valid = 1'b0;
          repeat ($urandom_range(1, DW)) step();
          SS_n = 1'b1; step();
          checks++; if (obs_en != 1 || MISO !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rand%0d send abort err=%0d MISO=%b busy=%b want 1/0/0", it, obs_en, MISO, busy); end
        end
      end
      end_frame();
      checks++; if (obs_en != 0 || busy !== 1'b0 || MISO !== 1'b0) begin errors++;
        $display("FAIL rand%0d release err=%0d busy=%b MISO=%b want 0/0/0", it, obs_en, busy, MISO); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [W-1:0] b;
    if (!m_as) begin
      b = {2'b10, 8'($urandom)};
      frame(1'b1, b, W); model_frame(1'b1, b, W); end_frame();
    end
    b = {2'b11, 8'($urandom)};
    frame(1'b1, b, W); model_frame(1'b1, b, W);
    tx_valid = 1'b1; tx_data = 8'hFF; step(); tx_valid = 1'b0;
    step(); step();
    checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL mid_send MISO got=%b want=1", MISO); end
    rst_n = 1'b0; step();
    checks++; if (MISO !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0 || err !== 1'b0 || rx_data !== '0) begin errors++;
      $display("FAIL mid_send reset MISO=%b busy=%b rx_valid=%b err=%b rx_data=%h want all 0",
               MISO, busy, rx_valid, err, rx_data); end
    rst_n = 1'b1; SS_n = 1'b1; step();
    m_rx = '0; m_as = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_flow();
    test_timeout();
    test_abort();
    test_mismatch();
    test_random();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
